// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the execution controller: state encodings,
// command codes and the soft-reset length.
package exec_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_STEP    = 3'd2,
        ST_HALTED  = 3'd3,
        ST_CPU_RST = 3'd4
    } exec_state_t;

    typedef enum logic [2:0] {
        CK_RUN,
        CK_STEP,
        CK_PAUSE,
        CK_CRST,
        CK_UNKNOWN
    } cmd_kind_t;

    localparam logic [7:0] CMD_RUN   = 8'h52;
    localparam logic [7:0] CMD_STEP  = 8'h53;
    localparam logic [7:0] CMD_PAUSE = 8'h50;
    localparam logic [7:0] CMD_CRST  = 8'h58;

    localparam int CPU_RST_LEN = 2;
    localparam int COUNT_W     = 32;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clr wins over en.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (en && !(&count_reg)) begin
            count_next = count_reg + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/exec_controller.sv
// Debug execution controller: turns host command bytes into CPU enable,
// single-step and soft-reset control, and counts enabled cycles.
module exec_controller
    import exec_ctrl_pkg::*;
#(
    parameter int CMD_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    input  logic [CMD_W-1:0] i_cmd,
    output logic             o_cmd_ready,
    input  logic             i_halt_wb,
    output logic             o_cpu_en,
    output logic             o_cpu_rst,
    output logic [2:0]       o_state,
    output logic [31:0]      o_cycle_count,
    output logic             o_step_ack,
    output logic             o_done,
    output logic             o_cmd_err
);

    exec_state_t state_reg, state_next;
    logic        rst_cnt_reg, rst_cnt_next;
    logic        done_reg, done_next;
    logic        err_reg, err_next;
    cmd_kind_t   cmd_kind;
    logic        accept;

    // Ready is decoded from state alone so i_cmd never reaches o_cmd_ready.
    assign o_cmd_ready = (state_reg == ST_IDLE) || (state_reg == ST_RUN) ||
                         (state_reg == ST_HALTED);
    assign accept      = i_cmd_valid && o_cmd_ready;

    always_comb begin
        cmd_kind = CK_UNKNOWN;
        if (i_cmd == CMD_W'(CMD_RUN)) begin
            cmd_kind = CK_RUN;
        end else if (i_cmd == CMD_W'(CMD_STEP)) begin
            cmd_kind = CK_STEP;
        end else if (i_cmd == CMD_W'(CMD_PAUSE)) begin
            cmd_kind = CK_PAUSE;
        end else if (i_cmd == CMD_W'(CMD_CRST)) begin
            cmd_kind = CK_CRST;
        end
    end

    always_comb begin
        state_next   = state_reg;
        rst_cnt_next = 1'b0;
        err_next     = accept && (cmd_kind == CK_UNKNOWN);
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_kind)
                        CK_RUN:  state_next = ST_RUN;
                        CK_STEP: state_next = ST_STEP;
                        CK_CRST: state_next = ST_CPU_RST;
                        default: state_next = ST_IDLE;
                    endcase
                end
            end
            ST_RUN: begin
                // Soft reset beats a retiring HALT, which beats PAUSE.
                if (accept && cmd_kind == CK_CRST) begin
                    state_next = ST_CPU_RST;
                end else if (i_halt_wb) begin
                    state_next = ST_HALTED;
                end else if (accept && cmd_kind == CK_PAUSE) begin
                    state_next = ST_IDLE;
                end
            end
            ST_STEP: begin
                state_next = i_halt_wb ? ST_HALTED : ST_IDLE;
            end
            ST_HALTED: begin
                if (accept && cmd_kind == CK_CRST) begin
                    state_next = ST_CPU_RST;
                end
            end
            ST_CPU_RST: begin
                if (rst_cnt_reg == 1'(CPU_RST_LEN - 1)) begin
                    state_next = ST_IDLE;
                end else begin
                    rst_cnt_next = rst_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        done_next = (state_next == ST_HALTED) && (state_reg != ST_HALTED);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= ST_IDLE;
            rst_cnt_reg <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rst_cnt_reg <= rst_cnt_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
        end
    end

    assign o_cpu_en   = (state_reg == ST_RUN) || (state_reg == ST_STEP);
    assign o_cpu_rst  = (state_reg == ST_CPU_RST);
    assign o_step_ack = (state_reg == ST_STEP);
    assign o_state    = state_reg;
    assign o_done     = done_reg;
    assign o_cmd_err  = err_reg;

    sat_counter #(
        .WIDTH(COUNT_W)
    ) u_cycle_counter (
        .clk  (i_clk),
        .srst (i_rst),
        .en   (o_cpu_en),
        .clr  (o_cpu_rst),
        .count(o_cycle_count)
    );

endmodule

// File: tb/tb_exec_controller.sv
// Randomized and directed bench for exec_controller against a cycle-level
// behavioural model of the command/step/halt/soft-reset rules.
module tb_exec_controller;

    logic        i_clk;
    logic        i_rst;
    logic        i_cmd_valid;
    logic [7:0]  i_cmd;
    logic        o_cmd_ready;
    logic        i_halt_wb;
    logic        o_cpu_en;
    logic        o_cpu_rst;
    logic [2:0]  o_state;
    logic [31:0] o_cycle_count;
    logic        o_step_ack;
    logic        o_done;
    logic        o_cmd_err;

    exec_controller #(.CMD_W(8)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_cmd_valid  (i_cmd_valid),
        .i_cmd        (i_cmd),
        .o_cmd_ready  (o_cmd_ready),
        .i_halt_wb    (i_halt_wb),
        .o_cpu_en     (o_cpu_en),
        .o_cpu_rst    (o_cpu_rst),
        .o_state      (o_state),
        .o_cycle_count(o_cycle_count),
        .o_step_ack   (o_step_ack),
        .o_done       (o_done),
        .o_cmd_err    (o_cmd_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Model: state number, true cycle count, remaining soft-reset cycles, pulses.
    int      m_state = 0;
    longint  m_cnt = 0;
    int      m_crst_left = 0;
    bit      m_done = 0;
    bit      m_err = 0;

    int ack_seen, en_seen, done_seen, err_seen, crst_seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_ready(input int s);
        return (s == 0) || (s == 1) || (s == 3);
    endfunction

    task automatic model_step(input bit v, input logic [7:0] c, input bit h, input bit r);
        int  nst;
        bit  acc;
        bit  known;
        if (r) begin
            m_state = 0; m_cnt = 0; m_crst_left = 0; m_done = 0; m_err = 0;
            return;
        end
        acc   = v && m_ready(m_state);
        known = (c == 8'h52) || (c == 8'h53) || (c == 8'h50) || (c == 8'h58);
        m_err = acc && !known;
        if (m_state == 4) m_cnt = 0;
        else if (m_state == 1 || m_state == 2) m_cnt = (m_cnt + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt + 1;
        nst = m_state;
        case (m_state)
            0: if (acc && c == 8'h52) nst = 1;
               else if (acc && c == 8'h53) nst = 2;
               else if (acc && c == 8'h58) nst = 4;
            1: if (acc && c == 8'h58) nst = 4;
               else if (h) nst = 3;
               else if (acc && c == 8'h50) nst = 0;
            2: nst = h ? 3 : 0;
            3: if (acc && c == 8'h58) nst = 4;
            4: begin
                m_crst_left--;
                if (m_crst_left == 0) nst = 0;
            end
            default: nst = 0;
        endcase
        if (nst == 4 && m_state != 4) m_crst_left = 2;
        m_done  = (nst == 3) && (m_state != 3);
        m_state = nst;
    endtask

    task automatic tick(input bit v, input logic [7:0] c, input bit h, input bit r);
        i_cmd_valid = v; i_cmd = c; i_halt_wb = h; i_rst = r;
        model_step(v, c, h, r);
        @(posedge i_clk);
        #1;
        check("state",     64'(o_state),       64'(m_state));
        check("cmd_ready", 64'(o_cmd_ready),   64'(m_ready(m_state)));
        check("cpu_en",    64'(o_cpu_en),      64'(m_state == 1 || m_state == 2));
        check("cpu_rst",   64'(o_cpu_rst),     64'(m_state == 4));
        check("step_ack",  64'(o_step_ack),    64'(m_state == 2));
        check("done",      64'(o_done),        64'(m_done));
        check("cmd_err",   64'(o_cmd_err),     64'(m_err));
        check("count",     64'(o_cycle_count), 64'(m_cnt));
        ack_seen  += int'(o_step_ack);
        en_seen   += int'(o_cpu_en);
        done_seen += int'(o_done);
        err_seen  += int'(o_cmd_err);
        crst_seen += int'(o_cpu_rst);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(0, 8'h00, 0, 0);
    endtask

    task automatic clear_seen();
        ack_seen = 0; en_seen = 0; done_seen = 0; err_seen = 0; crst_seen = 0;
    endtask

    initial begin
        i_rst = 1; i_cmd_valid = 0; i_cmd = 0; i_halt_wb = 0;
        tick(1, 8'h52, 1, 1);
        tick(0, 8'h00, 0, 1);
        check("reset_state", 64'(o_state), 64'd0);
        check("reset_ready", 64'(o_cmd_ready), 64'd1);

        // Three single steps spaced four cycles apart.
        clear_seen();
        for (int s = 0; s < 3; s++) begin
            tick(1, 8'h53, 0, 0);
            idle(3);
        end
        check("step3_acks", 64'(ack_seen), 64'd3);
        check("step3_en", 64'(en_seen), 64'd3);
        check("step3_count", 64'(o_cycle_count), 64'd3);

        // Run and halt on the tenth enabled cycle.
        tick(1, 8'h58, 0, 0);
        idle(3);
        clear_seen();
        tick(1, 8'h52, 0, 0);
        idle(9);
        tick(0, 8'h00, 1, 0);
        check("halt_count", 64'(o_cycle_count), 64'd10);
        check("halt_state", 64'(o_state), 64'd3);
        idle(4);
        check("halt_done_once", 64'(done_seen), 64'd1);
        check("halt_en_cycles", 64'(en_seen), 64'd10);

        // Commands in HALTED are dropped.
        clear_seen();
        tick(1, 8'h52, 0, 0);
        tick(1, 8'h53, 1, 0);
        idle(2);
        check("halted_stay", 64'(o_state), 64'd3);
        check("halted_no_en", 64'(en_seen), 64'd0);
        check("halted_no_err", 64'(err_seen), 64'd0);

        // CRST and HALT together in RUN: soft reset wins.
        tick(1, 8'h58, 0, 0);
        idle(3);
        tick(1, 8'h52, 0, 0);
        idle(2);
        clear_seen();
        tick(1, 8'h58, 1, 0);
        tick(0, 8'h00, 1, 0);
        idle(2);
        check("crst_len", 64'(crst_seen), 64'd2);
        check("crst_idle", 64'(o_state), 64'd0);
        check("crst_count", 64'(o_cycle_count), 64'd0);

        // Unknown code in IDLE.
        clear_seen();
        tick(1, 8'h41, 0, 0);
        idle(2);
        check("unk_err_once", 64'(err_seen), 64'd1);
        check("unk_state", 64'(o_state), 64'd0);

        // Saturation from a preloaded counter, then reset during a step.
        force dut.u_cycle_counter.count_next = 32'hFFFF_FFFE;
        m_cnt = 64'hFFFF_FFFE;
        tick(0, 8'h00, 0, 0);
        release dut.u_cycle_counter.count_next;
        tick(1, 8'h52, 0, 0);
        idle(5);
        check("sat_count", 64'(o_cycle_count), 64'hFFFF_FFFF);
        tick(1, 8'h50, 0, 0);
        tick(1, 8'h53, 0, 0);
        tick(1, 8'h52, 1, 1);
        check("rst_mid_step_state", 64'(o_state), 64'd0);
        check("rst_mid_step_count", 64'(o_cycle_count), 64'd0);

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            logic [7:0] c;
            int sel;
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1, 2: c = 8'h52;
                3, 4:    c = 8'h53;
                5:       c = 8'h50;
                6:       c = 8'h58;
                7:       c = 8'($urandom_range(0, 8'h4F));
                default: c = 8'($urandom_range(0, 255));
            endcase
            tick(($urandom_range(0, 1) == 1), c, ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 63) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/exec_controller.md
EXEC_CONTROLLER -- requirements
Module: exec_controller

Interface
REQ-001 The block SHALL have one clock, i_clk, and a synchronous, active-high reset, i_rst.
REQ-002 The block SHALL have a parameter CMD_W, default 8, giving the command byte width.
REQ-003 The block SHALL have these ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_cmd_valid  in  1  command byte present
- i_cmd  in  CMD_W  command code
- o_cmd_ready  out  1  command can be accepted
- i_halt_wb  in  1  HALT instruction retired this cycle
- o_cpu_en  out  1  pipeline/PC enable (inverse drives i_Stall)
- o_cpu_rst  out  1  soft reset to pipeline
- o_state  out  3  current state encoding
- o_cycle_count  out  32  enabled-cycle count
- o_step_ack  out  1  one-cycle pulse on the executed step cycle
- o_done  out  1  one-cycle pulse on HALTED entry
- o_cmd_err  out  1  one-cycle pulse on an unknown accepted command

Function
REQ-004 A command SHALL be accepted only in a cycle where i_cmd_valid=1 and o_cmd_ready=1.
REQ-005 Command codes SHALL be: RUN=0x52, STEP=0x53, PAUSE=0x50, CRST=0x58.
REQ-006 The states SHALL be IDLE=0, RUN=1, STEP=2, HALTED=3, CPU_RST=4.
REQ-007 The state register SHALL update on the clock edge after acceptance; outputs SHALL be Moore-decoded from the state.
REQ-008 o_cmd_ready SHALL be 1 in IDLE, RUN and HALTED, and 0 in STEP and CPU_RST.
REQ-009 o_cpu_en SHALL be 1 only in RUN and STEP.
REQ-010 o_cpu_rst SHALL be 1 only in CPU_RST.
REQ-011 IDLE transitions: RUN->RUN; STEP->STEP; CRST->CPU_RST; PAUSE is accepted with no effect.
REQ-012 RUN transitions: i_halt_wb=1->HALTED; PAUSE->IDLE; CRST->CPU_RST; RUN/STEP are accepted with no effect.
REQ-013 STEP SHALL last exactly one cycle, with o_step_ack=1 in that cycle; next state is HALTED if i_halt_wb=1, else IDLE.
REQ-014 In HALTED, only CRST SHALL change state (->CPU_RST); RUN, STEP and PAUSE are accepted and dropped.
REQ-015 CPU_RST SHALL last exactly 2 cycles, via a 1-bit sub-counter, and then go to IDLE.
REQ-016 Simultaneous events in RUN SHALL resolve by priority: CRST > i_halt_wb > PAUSE.
REQ-017 o_done SHALL pulse in the first cycle of HALTED only.
REQ-018 An accepted unknown code SHALL pulse o_cmd_err on the next cycle and leave the state unchanged.
REQ-019 o_cycle_count SHALL increment by 1 on each edge where o_cpu_en=1.
REQ-020 o_cycle_count SHALL saturate at 0xFFFFFFFF (no wrap-around).
REQ-021 o_cycle_count SHALL clear to 0 on every cycle spent in CPU_RST.
REQ-022 i_halt_wb SHALL be ignored in IDLE, HALTED and CPU_RST.

Reset
REQ-023 On i_rst=1 at an edge: state=IDLE, o_cycle_count=0, the CPU_RST sub-counter=0, and all pulses=0.
REQ-024 Reset values in the following cycle SHALL be: o_cpu_en=0, o_cpu_rst=0, o_cmd_ready=1, o_state=0.
REQ-025 i_rst SHALL override any in-progress STEP or CPU_RST, and any command presented in the same cycle SHALL be dropped.

Structure
REQ-026 State encodings, command codes and the CPU_RST length (2) SHALL live in the shared package exec_ctrl_pkg.
REQ-027 The saturating cycle counter SHALL be a sub-module, sat_counter, with width parameter 32, inputs en and clr, and output count.
REQ-028 The FSM SHALL be a single state register with next-state logic; no latches and no combinational path from i_cmd to o_cmd_ready.

Verification
REQ-029 Reset, then STEP x3 spaced 4 cycles apart -> exactly 3 cycles with o_cpu_en=1, 3 o_step_ack pulses, and o_cycle_count=3.
REQ-030 RUN, then i_halt_wb=1 at enabled cycle 10 -> o_cycle_count=10, state=3, o_done pulses once, and o_cpu_en=0 thereafter.
REQ-031 In RUN, present CRST and i_halt_wb in the same cycle -> o_cpu_rst=1 for 2 cycles, count=0, then IDLE with o_cmd_ready=1.
REQ-032 In HALTED, send RUN then STEP -> state stays 3, o_cpu_en stays 0, and o_cmd_err stays 0.
REQ-033 Send code 0x41 in IDLE -> o_cmd_err pulses once and the state stays 0.
REQ-034 Preload the counter to 0xFFFFFFFE and run 5 cycles -> o_cycle_count=0xFFFFFFFF; assert i_rst mid-STEP -> IDLE next cycle with count=0.
